// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and defaults for the bit-serial adder.
//   state_t      - controller states (IDLE, SHIFT, DONE)
//   SA_WIDTH_DEF - default operand/result width
package serial_adder_pkg;

  localparam int SA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake plus operand and result bus.
//   master (controller): drives start, a, b, c_in; reads busy, done, sum, c_out
//   slave  (adder)     : reads start, a, b, c_in; drives busy, done, sum, c_out
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out
  );

endinterface

// File: rtl/serial_adder_fa.sv
// full_adder: existing one-bit full adder cell.
//   a, b, c_in - operand bits and carry in
//   sum, c_out - sum bit and carry out
module full_adder (
  output logic sum,
  output logic c_out,
  input  logic a,
  input  logic b,
  input  logic c_in
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around one full_adder.
// Operands are shifted LSB first through the cell, the carry is held in a
// flop between bits, and sum bits accumulate into a shift register. The
// visible result register only changes on completion.
//   clk, rst - clock and synchronous active-high reset
//   bus      - slave side of serial_adder_if (start/a/b/c_in in,
//              busy/done/sum/c_out out)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int CNT_W = (WIDTH <= 1) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             c_out_q;
  logic             busy_q;
  logic             done_q;

  logic             fa_sum;
  logic             fa_c_out;

  full_adder u_fa (
    .sum   (fa_sum),
    .c_out (fa_c_out),
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c_in  (carry_q)
  );

  // New sum bit enters at the MSB; after WIDTH shifts the LSB has arrived
  // at bit 0. Written as shift/or so it also holds for WIDTH=1.
  assign acc_d = (acc_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            carry_q <= bus.c_in;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q   <= acc_d;
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          carry_q <= fa_c_out;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            // Last bit: publish the full result in the same edge.
            sum_q   <= acc_d;
            c_out_q <= fa_c_out;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst8 = 1'b1;
  logic rst1 = 1'b1;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(1)) if1 ();

  serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst8), .bus(if8.slave));
  serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));

  int n_cmp  = 0;
  int n_fail = 0;

  logic [8:0] sb8[$];
  logic [1:0] sb1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer sum of the operands, WIDTH+1 bits wide.
  function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int s;
    s = int'(a) + int'(b) + int'(c);
    return s[8:0];
  endfunction

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    logic [8:0] e;
    if (if8.done === 1'b1) begin
      if (sb8.size() == 0) begin
        chk("unexpected_done8", {23'd0, if8.c_out, if8.sum}, 32'hFFFF_FFFF);
      end else begin
        e = sb8.pop_front();
        chk("result8", {23'd0, if8.c_out, if8.sum}, {23'd0, e});
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (if1.done === 1'b1) begin
      if (sb1.size() == 0) begin
        chk("unexpected_done1", {30'd0, if1.c_out, if1.sum}, 32'hFFFF_FFFF);
      end else begin
        e = sb1.pop_front();
        chk("result1", {30'd0, if1.c_out, if1.sum}, {30'd0, e});
      end
    end
  end

  // Timing after the accepting edge: busy for 8 cycles, then one done cycle.
  task automatic expect_run8();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("busy8", {31'd0, if8.busy}, 32'd1);
      chk("no_done_while_busy8", {31'd0, if8.done}, 32'd0);
    end
    @(negedge clk);
    chk("done8", {31'd0, if8.done}, 32'd1);
    chk("busy_off_at_done8", {31'd0, if8.busy}, 32'd0);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit hold);
    @(negedge clk);
    if8.start = 1'b1;
    if8.a = a;
    if8.b = b;
    if8.c_in = c;
    sb8.push_back(ref8(a, b, c));
    @(posedge clk);
    #1;
    if (!hold) begin
      if8.start = 1'b0;
      if8.a = 8'($urandom);
      if8.b = 8'($urandom);
      if8.c_in = 1'($urandom);
    end else begin
      // start stays high with different operands through SHIFT and DONE
      if8.a = 8'hAA;
      if8.b = 8'h55;
      if8.c_in = 1'b0;
    end
    expect_run8();
    if (hold) begin
      @(negedge clk);
      chk("not_accepted_in_done8", {31'd0, if8.busy}, 32'd0);
      sb8.push_back(ref8(8'hAA, 8'h55, 1'b0));
      @(posedge clk);
      #1;
      if8.start = 1'b0;
      expect_run8();
    end
    @(negedge clk);
    chk("idle_busy8", {31'd0, if8.busy}, 32'd0);
    chk("idle_done8", {31'd0, if8.done}, 32'd0);
  endtask

  task automatic op1(input logic a, input logic b, input logic c);
    int s;
    @(negedge clk);
    if1.start = 1'b1;
    if1.a = a;
    if1.b = b;
    if1.c_in = c;
    s = int'(a) + int'(b) + int'(c);
    sb1.push_back(s[1:0]);
    @(posedge clk);
    #1;
    if1.start = 1'b0;
    if1.a = ~a;
    if1.b = ~b;
    if1.c_in = ~c;
    @(negedge clk);
    chk("busy1", {31'd0, if1.busy}, 32'd1);
    chk("no_done1", {31'd0, if1.done}, 32'd0);
    @(negedge clk);
    chk("done1", {31'd0, if1.done}, 32'd1);
    @(negedge clk);
    chk("idle1", {30'd0, if1.busy, if1.done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.c_in = 1'b0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.c_in = 1'b0;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy8", {31'd0, if8.busy}, 32'd0);
    chk("rst_done8", {31'd0, if8.done}, 32'd0);
    chk("rst_sum8", {23'd0, if8.c_out, if8.sum}, 32'd0);
    rst8 = 1'b0;
    rst1 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_after_rst8", {30'd0, if8.busy, if8.done}, 32'd0);
    end

    // Directed additions
    op8(8'h3C, 8'h0F, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0);
    op8(8'h00, 8'h00, 1'b1, 1'b0);

    // start ignored during SHIFT and DONE
    op8(8'h10, 8'h20, 1'b0, 1'b1);

    // Reset mid-operation
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'h7F; if8.b = 8'h7F; if8.c_in = 1'b0;
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst8 = 1'b1;
    @(posedge clk);
    #1;
    rst8 = 1'b0;
    @(negedge clk);
    chk("midrst_busy8", {31'd0, if8.busy}, 32'd0);
    chk("midrst_done8", {31'd0, if8.done}, 32'd0);
    chk("midrst_sum8", {23'd0, if8.c_out, if8.sum}, 32'd0);
    repeat (10) begin
      @(negedge clk);
      chk("no_done_after_abort8", {31'd0, if8.done}, 32'd0);
    end
    op8(8'h7F, 8'h7F, 1'b0, 1'b0);

    // Random operands
    for (int i = 0; i < 20; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    end

    // Exhaustive WIDTH=1
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1(v[2], v[1], v[0]);
    end

    repeat (5) @(negedge clk);
    chk("sb8_drained", sb8.size(), 32'd0);
    chk("sb1_drained", sb1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder that sits directly upstream of the existing `full_adder` cell. It feeds that cell one operand bit pair per clock, LSB first, and carries the cell's `c_out` in a flip-flop from bit to bit. It collects the `sum` bits into a result register. The block presents a start/busy/done handshake so a controller can launch additions and read back a stable `WIDTH`-bit sum plus final carry.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 1.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: synchronous reset, active-high.
- `start`  input  1: request a new addition; sampled only in IDLE.
- `a`  input  WIDTH: operand A; captured on the accepting edge.
- `b`  input  WIDTH: operand B; captured on the accepting edge.
- `c_in`  input  1: carry-in; captured on the accepting edge.
- `busy`  output  1: high while bits are being shifted through the adder.
- `done`  output  1: one-cycle pulse when `sum`/`c_out` are updated.
- `sum`  output  WIDTH: result of the last completed addition.
- `c_out`  output  1: carry-out of the last completed addition.

## Operation
- Reset values: state IDLE; `busy`=0, `done`=0, `sum`=0, `c_out`=0; shift registers, carry flop and bit counter = 0.
- **IDLE**:
  - `start`=1 at an edge: load `a_sh`←`a`, `b_sh`←`b`, `carry`←`c_in`, `cnt`←0, `acc`←0; go to SHIFT.
  - `start`=0: stay in IDLE.
- **SHIFT**, each cycle:
  - `full_adder` inputs: `a_sh[0]`, `b_sh[0]`, `carry`.
  - On the edge: `acc`←{fa_sum, `acc[WIDTH-1:1]`}; `a_sh`, `b_sh` shift right one position with 0 fill; `carry`←fa_c_out; `cnt`←`cnt`+1.
  - When `cnt`=WIDTH-1 on that edge, go to DONE.
  - Result register update on that same edge: `sum`←{fa_sum, `acc[WIDTH-1:1]`}, `c_out`←fa_c_out.
- **DONE**: `done`=1 for exactly one cycle; unconditionally return to IDLE. `start` is ignored in DONE.
- `start` is ignored in SHIFT; an in-flight operation cannot be restarted except by `rst`.
- `sum`/`c_out` hold their value from completion until the next completion; partial results never appear on them.
- Arithmetic: {`c_out`,`sum`} = `a` + `b` + `c_in`, modulo 2^(WIDTH+1). Wrap-around is expressed only through `c_out`; there is no overflow flag.
- Counter width: $clog2(WIDTH+1) bits, minimum 1.
- WIDTH=1: a single SHIFT cycle, then DONE.
- `rst` asserted in any state, including mid-SHIFT: the operation is aborted and all state and outputs return to reset values on that edge. `rst` has priority over `start`.

## Timing
- `start` accepted at edge t:
  - `busy`=1 for cycles t+1 … t+WIDTH.
  - `sum`/`c_out` valid and `done`=1 in cycle t+WIDTH+1.
  - IDLE again at t+WIDTH+2.
- Latency from the accepting edge to `done` is WIDTH+1 cycles.
- Maximum throughput is one addition per WIDTH+2 cycles.
- `busy` and `done` are registered outputs, never high together.
- `a`, `b`, `c_in` may change freely after the accepting edge.
- The only combinational path is through `full_adder`, one bit deep per cycle.

## Structure
- Package `serial_adder_pkg`:
  - `state_t` enum {IDLE, SHIFT, DONE}.
  - localparam for the default WIDTH.
- Sub-module: exactly one instance of the existing `full_adder`. Its ports are `sum`, `c_out`, `a`, `b`, `c_in`, connected by name.
- Everything else lives in `serial_adder`: FSM, shift registers, carry flop, counter, result register.

## Test plan
All scenarios use WIDTH=8 unless stated otherwise.
- Reset: hold `rst` 2 cycles → `busy`=0, `done`=0, `sum`=8'h00, `c_out`=0; `start`=0 afterwards keeps IDLE.
- Basic add: `a`=8'h3C, `b`=8'h0F, `c_in`=0, pulse `start` at edge t → `busy` high t+1..t+8; `done` in cycle t+9 with `sum`=8'h4B, `c_out`=0.
- Wrap/carry: 8'hFF+8'h01, `c_in`=0 → `sum`=8'h00, `c_out`=1. Also 8'h00+8'h00, `c_in`=1 → `sum`=8'h01, `c_out`=0.
- Ignored start: during SHIFT of 8'h10+8'h20, assert `start` with `a`=8'hAA → result 8'h30, single `done`. Then `start` held high through DONE → next operation accepted only in the following IDLE cycle.
- Reset mid-operation: assert `rst` at t+4 of 8'h7F+8'h7F → outputs 0, no `done`. A fresh 8'h7F+8'h7F → `sum`=8'hFE, `c_out`=0.
- Exhaustive WIDTH=1: all 8 {`a`,`b`,`c_in`} combinations → `done` two cycles after each start. Each {`c_out`,`sum`} matches `a`+`b`+`c_in`.
